acc_posit_normalize: RTL and testbench

//  Downstream of the segmented quire accumulator. Captures the five accumulator segments once the
//  K-term dot product is complete, reassembles them into one two's-complement fixed-point word, and

---
 rtl/acc_posit_normalize.sv | 177 +++++++++++++++++
 tb/tb_acc_posit_normalize.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_posit_normalize.sv
// Reassembles the five quire segments into one fixed-point word and rounds it to a WIDTH-bit posit.
// Build option: define ACC_NORM_STICKY_EN for round-to-nearest-even; otherwise round half away from zero.
module acc_posit_normalize #(
    parameter int WIDTH    = 8,
    parameter int K        = 9,
    parameter int EXP      = 2,
    parameter int ACC      = (2**EXP)*(WIDTH-2),
    parameter int ACC_HEAD = $clog2(K)+2,
    parameter int FRAC     = 2*ACC,
    parameter int TW       = ACC_HEAD+4*ACC
) (
    input  logic                clk_i,
    input  logic                rstn,
    input  logic                acc_rdy,
    input  logic [ACC_HEAD-1:0] acc_000_c,
    input  logic [ACC-1:0]      acc_001_c,
    input  logic [ACC-1:0]      acc_010_c,
    input  logic [ACC-1:0]      acc_011_c,
    input  logic [ACC-1:0]      acc_100_c,
    output logic                out_vld,
    input  logic                out_rdy,
    output logic [WIDTH-1:0]    posit_o,
    output logic                busy,
    output logic                drop
);

    localparam int MW  = $clog2(TW+1);
    localparam int SW  = MW + 2;
    localparam int RW  = WIDTH;
    localparam int RLW = $clog2(RW+1);
    localparam int LW  = RW + EXP + TW;
    localparam logic signed [SW-1:0] KMAX   = SW'(WIDTH-2);
    localparam logic [WIDTH-2:0]     MAXPOS = '1;
    localparam logic [WIDTH-2:0]     MINPOS = (WIDTH-1)'(1);

    typedef enum logic [2:0] {IDLE, ABS, LZD, PACK, HOLD} state_t;
    state_t state_q, state_d;

    logic                 acc_rdy_q;
    logic                 start;
    logic signed [TW-1:0] f_p0;
    logic                 sgn_p1;
    logic [TW:0]          mag_p1;
    logic [MW-1:0]        msb_p2;
    logic                 zero_p2;

    logic signed [TW:0]   f_ext;
    logic [TW:0]          mag_d;
    logic [MW-1:0]        msb_d;

    logic signed [SW-1:0] scale;
    logic signed [SW-1:0] k_reg;
    logic [SW-1:0]        k_neg;
    logic [EXP-1:0]       e_bits;
    logic [TW:0]          aligned;
    logic [RW-1:0]        rpat;
    logic [RLW-1:0]       rlen;
    logic [LW-1:0]        bits_str;
    logic [WIDTH-2:0]     body;
    logic [WIDTH-2:0]     body_rnd;
    logic                 rbit;
    logic [WIDTH-1:0]     posit_d;
    logic                 unused_bits;

    // Adds the round bit; a carry out of the body saturates, a zero result is lifted to minpos.
    function automatic logic [WIDTH-2:0] round_body(input logic [WIDTH-2:0] b, input logic r);
        logic [WIDTH-1:0] sum;
        sum = {1'b0, b} + {{(WIDTH-1){1'b0}}, r};
        if (sum[WIDTH-1]) return MAXPOS;
        if (sum == '0)    return MINPOS;
        return sum[WIDTH-2:0];
    endfunction

    function automatic logic [WIDTH-1:0] apply_sign(input logic s, input logic [WIDTH-2:0] b);
        return s ? -{1'b0, b} : {1'b0, b};
    endfunction

    assign start = acc_rdy & ~acc_rdy_q;
    assign busy  = (state_q != IDLE);
    assign drop  = rstn & start & busy;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = ABS;
            ABS:     state_d = LZD;
            LZD:     state_d = PACK;
            PACK:    state_d = HOLD;
            HOLD:    if (out_rdy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn) begin
            state_q   <= IDLE;
            acc_rdy_q <= 1'b0;
            out_vld   <= 1'b0;
            posit_o   <= '0;
        end else begin
            state_q   <= state_d;
            acc_rdy_q <= acc_rdy;
            if (state_q == PACK) begin
                out_vld <= 1'b1;
                posit_o <= posit_d;
            end else if (state_q == HOLD && out_rdy) begin
                out_vld <= 1'b0;
            end
        end
    end

    always_comb begin
        f_ext = {f_p0[TW-1], f_p0};
        mag_d = f_ext[TW] ? $unsigned(-f_ext) : $unsigned(f_ext);
    end

    always_comb begin
        msb_d = '0;
        for (int i = 0; i <= TW; i++)
            if (mag_p1[i]) msb_d = MW'(i);
    end

    always_ff @(posedge clk_i) begin
        // p0: capture the reassembled accumulator word
        if (state_q == IDLE && start)
            f_p0 <= {acc_000_c, acc_001_c, acc_010_c, acc_011_c, acc_100_c};
        // p1: sign and magnitude
        if (state_q == ABS) begin
            sgn_p1 <= f_p0[TW-1];
            mag_p1 <= mag_d;
        end
        // p2: leading-one position
        if (state_q == LZD) begin
            msb_p2  <= msb_d;
            zero_p2 <= ~|mag_p1;
        end
    end

    // The body string is regime, exponent, then fraction, built left-aligned in bits_str.
    always_comb begin
        scale   = SW'(msb_p2) - SW'(FRAC);
        k_reg   = scale >>> EXP;
        k_neg   = -k_reg;
        e_bits  = scale[EXP-1:0];
        aligned = mag_p1 << (MW'(TW) - msb_p2);
        if (!k_reg[SW-1]) begin
            rpat = ~({RW{1'b1}} >> (RLW'(k_reg) + RLW'(1)));
            rlen = RLW'(k_reg) + RLW'(2);
        end else begin
            rpat = {1'b1, {(RW-1){1'b0}}} >> RLW'(k_neg);
            rlen = RLW'(k_neg) + RLW'(1);
        end
        bits_str = {rpat, {(EXP+TW){1'b0}}}
                 | ({{RW{1'b0}}, e_bits, aligned[TW-1:0]} << (RLW'(RW) - rlen));
        body = bits_str[LW-1 -: WIDTH-1];
`ifdef ACC_NORM_STICKY_EN
        rbit = bits_str[LW-WIDTH] & (bits_str[LW-WIDTH+1] | (|bits_str[LW-WIDTH-1:0]));
`else
        rbit = bits_str[LW-WIDTH];
`endif
        body_rnd = '0;
        posit_d  = '0;
        if (!zero_p2) begin
            if (k_reg >= KMAX)       body_rnd = MAXPOS;
            else if (k_reg < -KMAX)  body_rnd = MINPOS;
            else                     body_rnd = round_body(body, rbit);
            posit_d = apply_sign(sgn_p1, body_rnd);
        end
    end

`ifdef ACC_NORM_STICKY_EN
    assign unused_bits = aligned[TW];
`else
    assign unused_bits = ^{aligned[TW], bits_str[LW-WIDTH-1:0]};
`endif

endmodule

// File: tb/tb_acc_posit_normalize.sv
// Directed bench for acc_posit_normalize: bit-string posit model plus protocol model, checked every cycle.
module tb_acc_posit_normalize;

    logic         clk_i = 1'b0;
    logic         rstn;
    logic         acc_rdy;
    logic         out_rdy;
    logic [101:0] fvec;
    logic         out_vld;
    logic [7:0]   posit_o;
    logic         busy;
    logic         drop;

    always #5 clk_i = ~clk_i;

    acc_posit_normalize dut (
        .clk_i     (clk_i),
        .rstn      (rstn),
        .acc_rdy   (acc_rdy),
        .acc_000_c (fvec[101:96]),
        .acc_001_c (fvec[95:72]),
        .acc_010_c (fvec[71:48]),
        .acc_011_c (fvec[47:24]),
        .acc_100_c (fvec[23:0]),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .posit_o   (posit_o),
        .busy      (busy),
        .drop      (drop)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Value-level model: write out the posit bit string field by field, then round it.
    function automatic logic [7:0] posit_model(input logic [101:0] f);
        logic [102:0] mag;
        bit           sgn;
        bit           bits[$];
        int           m, s, k, e, body;
        sgn = f[101];
        mag = {f[101], f};
        if (sgn) mag = ~mag + 103'd1;
        if (mag == 0) return 8'h00;
        m = 0;
        for (int i = 0; i < 103; i++) if (mag[i]) m = i;
        s = m - 48;
        k = (s >= 0) ? s / 4 : -((3 - s) / 4);
        e = s - 4 * k;
        if (k >= 6) body = 127;
        else if (k < -6) body = 1;
        else begin
            if (k >= 0) begin
                for (int i = 0; i <= k; i++) bits.push_back(1'b1);
                bits.push_back(1'b0);
            end else begin
                for (int i = 0; i < -k; i++) bits.push_back(1'b0);
                bits.push_back(1'b1);
            end
            bits.push_back(((e >> 1) & 1) != 0);
            bits.push_back((e & 1) != 0);
            for (int i = m - 1; i >= 0; i--) bits.push_back(mag[i]);
            while (bits.size() < 8) bits.push_back(1'b0);
            body = 0;
            for (int i = 0; i < 7; i++) body = body * 2 + (bits[i] ? 1 : 0);
`ifdef ACC_NORM_STICKY_EN
            begin
                bit st;
                st = 1'b0;
                for (int i = 8; i < bits.size(); i++) st |= bits[i];
                if (bits[7] && (bits[6] || st)) body++;
            end
`else
            if (bits[7]) body++;
`endif
            if (body > 127) body = 127;
            if (body < 1) body = 1;
        end
        return sgn ? 8'(-body) : 8'(body);
    endfunction

    // Protocol model: phase 0 idle, 1..3 working, 4 result presented.
    int         ph = 0;
    logic [7:0] exp_p = 8'h00;
    logic       prev_rdy = 1'b0;
    bit         chk_en = 1'b0;
    int         drop_cnt = 0;

    always @(posedge clk_i) begin
        if (!rstn) begin
            ph       <= 0;
            prev_rdy <= 1'b0;
        end else begin
            prev_rdy <= acc_rdy;
            if (ph == 0) begin
                if (acc_rdy && !prev_rdy) begin
                    ph    <= 1;
                    exp_p <= posit_model(fvec);
                end
            end else if (ph < 4) ph <= ph + 1;
            else if (out_rdy) ph <= 0;
        end
    end

    always @(negedge clk_i) begin
        if (drop === 1'b1) drop_cnt++;
        if (chk_en) begin
            check("out_vld", 64'(out_vld), 64'(ph == 4));
            check("busy", 64'(busy), 64'(ph != 0));
            check("drop", 64'(drop), 64'(rstn && acc_rdy && !prev_rdy && ph != 0));
            if (ph == 4) check("posit_o", 64'(posit_o), 64'(exp_p));
        end
    end

    task automatic run(input logic [101:0] f, input logic [7:0] lit, input int hold, input bit redge);
        int lat;
        bit got;
        @(posedge clk_i); #1;
        fvec    = f;
        acc_rdy = 1'b1;
        out_rdy = (hold == 0);
        lat = 0;
        got = 1'b0;
        while (!got && lat < 10) begin
            @(posedge clk_i);
            @(negedge clk_i);
            lat++;
            got = (out_vld === 1'b1);
        end
        check("latency", 64'(lat), 64'd4);
        check("posit_lit", 64'(posit_o), 64'(lit));
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                @(posedge clk_i); #1;
                if (redge) acc_rdy = (c != 0);
            end
            out_rdy = 1'b1;
        end
        @(posedge clk_i); #1;
        acc_rdy = 1'b0;
        out_rdy = 1'b1;
    endtask

    logic [101:0] fv[16];
    logic [7:0]   lv[16];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        fv[0]  = '0;                   lv[0]  = 8'h00;
        fv[1]  = 102'(1) << 48;        lv[1]  = 8'h40;
        fv[2]  = -(102'(1) << 48);     lv[2]  = 8'hC0;
        fv[3]  = 102'(3) << 47;        lv[3]  = 8'h44;
        fv[4]  = -(102'(3) << 47);     lv[4]  = 8'hBC;
        fv[5]  = 102'(1) << 72;        lv[5]  = 8'h7F;
        fv[6]  = 102'(1) << 100;       lv[6]  = 8'h7F;
        fv[7]  = -(102'(1) << 80);     lv[7]  = 8'h81;
        fv[8]  = 102'(1);              lv[8]  = 8'h01;
        fv[9]  = 102'(17) << 44;
`ifdef ACC_NORM_STICKY_EN
        lv[9]  = 8'h40;
`else
        lv[9]  = 8'h41;
`endif
        fv[10] = 102'(1) << 44;        lv[10] = 8'h20;
        fv[11] = 102'(1) << 101;       lv[11] = 8'h81;
        fv[12] = 102'(1) << 68;        lv[12] = 8'h7E;
        fv[13] = 102'(1) << 71;        lv[13] = 8'h7F;
        fv[14] = 102'(1) << 27;        lv[14] = 8'h02;
        fv[15] = 102'(1) << 23;        lv[15] = 8'h01;

        rstn    = 1'b0;
        acc_rdy = 1'b0;
        out_rdy = 1'b1;
        fvec    = '0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_out_vld", 64'(out_vld), 64'd0);
        check("rst_posit", 64'(posit_o), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_drop", 64'(drop), 64'd0);
        rstn   = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < 16; i++) run(fv[i], lv[i], 0, 1'b0);

        drop_cnt = 0;
        run(102'(3) << 47, 8'h44, 3, 1'b1);
        check("drop_count", 64'(drop_cnt), 64'd1);
        cnt = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (out_vld === 1'b1) cnt++;
        end
        check("no_second_result", 64'(cnt), 64'd0);

        @(posedge clk_i); #1;
        fvec    = 102'(1) << 48;
        acc_rdy = 1'b1;
        out_rdy = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i); #1;
        rstn    = 1'b0;
        acc_rdy = 1'b0;
        @(posedge clk_i); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_out_vld", 64'(out_vld), 64'd0);
        rstn = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge clk_i);
            if (out_vld === 1'b1) cnt++;
        end
        check("abort_no_output", 64'(cnt), 64'd0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
